demux32_collect: RTL

- Inverse of the 32-way 4-bit select path.
- Accepts a stream of nibbles over a valid/ready handshake.
- Distributes each nibble into one of 32 registered output lanes, either by explicit lane address or by an auto-incrementing pointer.
- Once every lane has been written, it flags a complete frame and holds it until the consumer acknowledges. This is the writer-side feeder for the 32-input selector bank.

---
 rtl/demux32_collect.sv | 103 ++++++++++
 1 files changed

// File: rtl/demux32_collect.sv
// Nibble-stream collector: scatters accepted nibbles into LANES registered lanes
//   (addressed or pointer-sequential) and holds a complete frame until acknowledged.
// Latency: written data appears on q one cycle after the transfer edge.
// Backpressure: in_ready is registered, high while filling and low while a full frame is held.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; a transfer is in_valid & in_ready at a clock edge
//   d, mode, s          nibble, lane-select mode (0 = lane s, 1 = lane ptr), addressed lane
//   q                   all lanes packed, lane i on q[W*i +: W]
//   lane_valid          per-lane written flag for the current frame
//   ptr                 next lane for sequential writes
//   frame_done          one-cycle pulse the cycle after the frame becomes complete
//   out_ack             consumer releases a held frame
module demux32_collect #(
  parameter int W     = 4,
  parameter int LANES = 32,
  localparam int SW   = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       d,
  input  logic               mode,
  input  logic [SW-1:0]      s,
  output logic [LANES*W-1:0] q,
  output logic [LANES-1:0]   lane_valid,
  output logic [SW-1:0]      ptr,
  output logic               frame_done,
  input  logic               out_ack
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state;

  logic [SW-1:0]    lane;
  logic [LANES-1:0] lane_hit;
  logic             xfer;
  logic             completes;
  logic [SW-1:0]    ptr_next;

  always_comb begin
    lane      = mode ? ptr : s;
    lane_hit  = LANES'(1) << lane;
    // in_ready mirrors state (FILL), so it doubles as the transfer qualifier.
    xfer      = in_valid & in_ready;
    // Completion looks at the flags including this write, independent of ptr.
    completes = &(lane_valid | lane_hit);
    ptr_next  = (ptr == SW'(LANES - 1)) ? '0 : ptr + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      in_ready   <= 1'b1;
      q          <= '0;
      lane_valid <= '0;
      ptr        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (xfer) begin
            for (int i = 0; i < LANES; i++) begin
              if (lane_hit[i]) begin
                q[W*i +: W] <= d;
              end
            end
            lane_valid <= lane_valid | lane_hit;
            if (mode) begin
              ptr <= ptr_next;
            end
            if (completes) begin
              state      <= FULL;
              in_ready   <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        FULL: begin
          // q is deliberately kept: stale data is masked by lane_valid.
          if (out_ack) begin
            lane_valid <= '0;
            ptr        <= '0;
            state      <= FILL;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
